sipo_controller: RTL and testbench

Receive-side counterpart of the PISO load/shift controller. Accepts a serial bit stream one bit per qualified cycle, assembles WIDTH bits into a parallel word, then presents the word with a valid/ready handshake. It contains the control FSM, the bit counter and the shift register, and sits between a serial link and a parallel consumer.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_bit_counter.sv | 38 +++
 rtl/sipo_controller.sv | 134 +++++++++++++
 tb/tb_sipo_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in / parallel-out receive controller.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted serial bits of one word; 'last' flags the final data bit.
module sipo_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  import sipo_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at WIDTH-1 so a power-of-two WIDTH cannot wrap inside a word.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_controller.sv
// Serial-to-parallel receiver: assembles WIDTH bits and offers them via valid/ready.
// Optional trailing even-parity bit and parity_err output with SIPO_PARITY_EN.
module sipo_controller #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);
  import sipo_pkg::*;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] pout_q;
  logic             pout_valid_q;
  logic             busy_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;
`ifdef SIPO_PARITY_EN
  logic             par_q;
  logic             parity_err_q;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    if (MSB_FIRST != 0) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  assign sr_d    = shift_in(sr_q, sin);
  assign cnt_clr = (state_q == IDLE) && start;
  assign cnt_en  = (state_q == SHIFT) && sin_valid;

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last)
  );

  // pout_q is a separate holding register so the consumer sees a stable word
  // while the next reception is already shifting into sr_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
`ifdef SIPO_PARITY_EN
            par_q   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            sr_q <= sr_d;
`ifdef SIPO_PARITY_EN
            par_q <= par_q ^ sin;
            if (cnt_last) begin
              state_q <= PARITY;
            end
`else
            if (cnt_last) begin
              state_q      <= DONE;
              pout_q       <= sr_d;
              pout_valid_q <= 1'b1;
            end
`endif
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          if (sin_valid) begin
            state_q      <= DONE;
            pout_q       <= sr_q;
            pout_valid_q <= 1'b1;
            parity_err_q <= par_q ^ sin;
          end
        end
`endif
        DONE: begin
          if (pout_ready) begin
            state_q      <= IDLE;
            pout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign busy       = busy_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_controller.sv
// Directed bench for sipo_controller: MSB-first and LSB-first instances share stimulus.
module tb_sipo_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       pout_ready = 1'b0;
  logic [7:0] pout_m;
  logic [7:0] pout_l;
  logic       pv_m;
  logic       pv_l;
  logic       busy_m;
  logic       busy_l;
`ifdef SIPO_PARITY_EN
  logic       perr_m;
  logic       perr_l;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_controller #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .pout       (pout_m),
    .pout_valid (pv_m),
    .pout_ready (pout_ready),
    .busy       (busy_m)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (perr_m)
`endif
  );

  sipo_controller #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .pout       (pout_l),
    .pout_valid (pv_l),
    .pout_ready (pout_ready),
    .busy       (busy_l)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (perr_l)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] em, input logic [7:0] el,
                            input logic v, input logic b);
    chk({tag, ".pout_msb"}, {24'd0, pout_m}, {24'd0, em});
    chk({tag, ".pout_lsb"}, {24'd0, pout_l}, {24'd0, el});
    chk({tag, ".valid_msb"}, {31'd0, pv_m}, {31'd0, v});
    chk({tag, ".valid_lsb"}, {31'd0, pv_l}, {31'd0, v});
    chk({tag, ".busy_msb"}, {31'd0, busy_m}, {31'd0, b});
    chk({tag, ".busy_lsb"}, {31'd0, busy_l}, {31'd0, b});
  endtask

  // Raises start together with a noise bit that must not be shifted in.
  task automatic start_now();
    start     = 1'b1;
    sin_valid = 1'b1;
    sin       = 1'b1;
  endtask

  // Sends b[7] first; with gap, idle cycles (carrying a stray start) separate bits.
  task automatic send_bits(input logic [7:0] b, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      if (gap && i != 7) begin
        @(negedge clk);
        sin_valid = 1'b0;
        start     = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      if (i == 7) chk("busy_after_start", {31'd0, busy_m}, 32'd1);
      if (i == 0) chk("valid_before_last", {31'd0, pv_m}, 32'd0);
      sin       = b[i];
      sin_valid = 1'b1;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Word 1: B2, valid every cycle, then DONE held with ready low.
    @(negedge clk);
    start_now();
    send_bits(8'hB2, 1'b0);
    @(negedge clk);
    sin_valid = 1'b0;
    expect_out("w1", 8'hB2, 8'h4D, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start     = 1'b1;
      sin_valid = 1'b1;
      sin       = k[0];
      expect_out("w1_hold", 8'hB2, 8'h4D, 1'b1, 1'b1);
    end
    @(negedge clk);
    start      = 1'b0;
    sin_valid  = 1'b0;
    pout_ready = 1'b1;
    expect_out("w1_hold_last", 8'hB2, 8'h4D, 1'b1, 1'b1);
    @(negedge clk);
    pout_ready = 1'b0;
    expect_out("w1_hs", 8'hB2, 8'h4D, 1'b0, 1'b0);

    // Word 2: back-to-back start, B2 with gapped sin_valid.
    start_now();
    send_bits(8'hB2, 1'b1);
    @(negedge clk);
    sin_valid = 1'b0;
    expect_out("w2", 8'hB2, 8'h4D, 1'b1, 1'b1);
    pout_ready = 1'b1;
    @(negedge clk);
    expect_out("w2_hs", 8'hB2, 8'h4D, 1'b0, 1'b0);

    // Word 3: 5A with ready held high throughout.
    start_now();
    send_bits(8'h5A, 1'b0);
    @(negedge clk);
    sin_valid = 1'b0;
    expect_out("w3", 8'h5A, 8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    pout_ready = 1'b0;
    expect_out("w3_hs", 8'h5A, 8'h5A, 1'b0, 1'b0);

    // Abort after 4 bits with asynchronous reset, then a clean FF word.
    start_now();
    for (int i = 7; i >= 4; i--) begin
      @(negedge clk);
      start     = 1'b0;
      sin       = 1'b1;
      sin_valid = 1'b1;
    end
    @(negedge clk);
    sin_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect_out("abort", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("post_abort", 8'h00, 8'h00, 1'b0, 1'b0);
    start_now();
    send_bits(8'hFF, 1'b0);
    @(negedge clk);
    sin_valid = 1'b0;
    expect_out("wff", 8'hFF, 8'hFF, 1'b1, 1'b1);
    pout_ready = 1'b1;
    @(negedge clk);
    pout_ready = 1'b0;
    expect_out("wff_hs", 8'hFF, 8'hFF, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      start_now();
      send_bits(8'hB2, 1'b0);
      @(negedge clk);
      chk("par_wait_valid", {31'd0, pv_m}, 32'd0);
      sin       = p[0];
      sin_valid = 1'b1;
      @(negedge clk);
      sin_valid = 1'b0;
      expect_out("par", 8'hB2, 8'h4D, 1'b1, 1'b1);
      chk("par_err_msb", {31'd0, perr_m}, p);
      chk("par_err_lsb", {31'd0, perr_l}, p);
      pout_ready = 1'b1;
      @(negedge clk);
      pout_ready = 1'b0;
      chk("par_err_hold", {31'd0, perr_m}, p);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
